alu_iterative: RTL

//  Execute unit downstream of alu_control: consumes the 5-bit alu_function code plus two

---
 rtl/alu_iterative_if.sv | 28 ++
 rtl/alu_iterative.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_iterative_if.sv
// Request/response bundle between alu_control-side issue logic and the iterative ALU.
// Carries no state and adds no latency.
// Both directions use valid/ready; ownership of each signal is fixed by the modports.
interface alu_iterative_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_function;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            result_equal_zero;

  // Upstream issuer and downstream consumer side.
  modport master (
    output in_valid, alu_function, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, result_equal_zero
  );

  // ALU side.
  modport slave (
    input  in_valid, alu_function, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, result_equal_zero
  );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle arith/logic/compare ops; shifts done SHIFT_STEP bits per cycle.
// Latency: result valid the cycle after accept, or ceil(shamt/SHIFT_STEP) cycles later for shifts.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; one op in flight.
module alu_iterative #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic         clock,
  input logic         reset_n,
  alu_iterative_if.slave bus
);

  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_SLL  = 5'b00011;
  localparam logic [4:0] ALU_SRL  = 5'b00100;
  localparam logic [4:0] ALU_SRA  = 5'b00101;
  localparam logic [4:0] ALU_SEQ  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_SLTU = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b01001;
  localparam logic [4:0] ALU_OR   = 5'b01010;
  localparam logic [4:0] ALU_AND  = 5'b01011;

  localparam logic [1:0] KIND_LL = 2'd0;
  localparam logic [1:0] KIND_RL = 2'd1;
  localparam logic [1:0] KIND_RA = 2'd2;

  localparam logic [4:0] STEP_W = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] result_q, result_next;
  logic            zero_q, zero_next;
  logic [4:0]      count, count_next;
  logic [1:0]      kind, kind_next;

  logic [XLEN-1:0] alu_res;
  logic            is_shift;
  logic [1:0]      shift_kind;
  logic [4:0]      shamt;
  logic [4:0]      step_amt;
  logic [XLEN-1:0] shifted;

  assign shamt = bus.operand_b[4:0];

  // Single-cycle op decode; unknown codes fall to the default and give zero.
  always_comb begin
    alu_res    = '0;
    is_shift   = 1'b0;
    shift_kind = KIND_LL;
    case (bus.alu_function)
      ALU_ADD:  alu_res = bus.operand_a + bus.operand_b;
      ALU_SUB:  alu_res = bus.operand_a - bus.operand_b;
      ALU_AND:  alu_res = bus.operand_a & bus.operand_b;
      ALU_OR:   alu_res = bus.operand_a | bus.operand_b;
      ALU_XOR:  alu_res = bus.operand_a ^ bus.operand_b;
      ALU_SLT:  alu_res = XLEN'($signed(bus.operand_a) < $signed(bus.operand_b));
      ALU_SLTU: alu_res = XLEN'(bus.operand_a < bus.operand_b);
      ALU_SEQ:  alu_res = XLEN'(bus.operand_a == bus.operand_b);
      ALU_SLL:  begin is_shift = 1'b1; shift_kind = KIND_LL; end
      ALU_SRL:  begin is_shift = 1'b1; shift_kind = KIND_RL; end
      ALU_SRA:  begin is_shift = 1'b1; shift_kind = KIND_RA; end
      default:  alu_res = '0;
    endcase
  end

  // One shift step on the working value held in the result register.
  always_comb begin
    step_amt = (count < STEP_W) ? count : STEP_W;
    case (kind)
      KIND_RL: shifted = result_q >> step_amt;
      KIND_RA: shifted = $signed(result_q) >>> step_amt;
      default: shifted = result_q << step_amt;
    endcase
  end

  // Next-state and datapath update; the result register doubles as the shift working register.
  always_comb begin
    state_next  = state;
    result_next = result_q;
    count_next  = count;
    kind_next   = kind;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_shift) begin
            result_next = bus.operand_a;
            kind_next   = shift_kind;
            if (shamt == 5'd0) begin
              state_next = DONE;
            end else begin
              count_next = shamt;
              state_next = SHIFT;
            end
          end else begin
            result_next = alu_res;
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        result_next = shifted;
        count_next  = count - step_amt;
        if (count == step_amt) state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    zero_next = (result_next == '0);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      count    <= '0;
      kind     <= KIND_LL;
    end else begin
      state    <= state_next;
      result_q <= result_next;
      zero_q   <= zero_next;
      count    <= count_next;
      kind     <= kind_next;
    end
  end

  assign bus.in_ready          = (state == IDLE);
  assign bus.out_valid         = (state == DONE);
  assign bus.result            = result_q;
  assign bus.result_equal_zero = zero_q;

endmodule
